// File: rtl/game_pkg.sv
// Shared types and constants for the LED memory game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GEN,
    S_SHOW,
    S_INPUT,
    S_JUDGE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [2:0]  LV_8    = 3'b001;
  localparam logic [2:0]  LV_12   = 3'b010;
  localparam logic [2:0]  LV_16   = 3'b100;

  localparam logic [15:0] MASK_8  = 16'h00FF;
  localparam logic [15:0] MASK_12 = 16'h0FFF;
  localparam logic [15:0] MASK_16 = 16'hFFFF;

  function automatic logic level_ok(input logic [2:0] lv);
    return (lv == LV_8) || (lv == LV_12) || (lv == LV_16);
  endfunction

  function automatic logic [15:0] level_mask(input logic [2:0] lv);
    case (lv)
      LV_8:    return MASK_8;
      LV_12:   return MASK_12;
      LV_16:   return MASK_16;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable down-counter with zero flag; shared by the clear, gap and input-timeout waits.
module seq_delay_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/game_round_sequencer.sv
// Round sequencer for the LED memory game: drives generator/printer/trimmer,
// judges each round, counts results and publishes the final score.
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned POINTS       = 10,
  parameter int unsigned CLR_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES   = 3,
  parameter int unsigned TRIM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  level,
  input  logic        level_valid,
  input  logic        gen_done,
  input  logic        print_done,
  input  logic        trim_done,
  input  logic        round_win,
  output logic        sub_clr,
  output logic        gen_start,
  output logic        print_start,
  output logic        trim_start,
  output logic [15:0] lv_enable,
  output logic [4:0]  round_count,
  output logic [4:0]  answer_count,
  output logic [6:0]  score,
  output logic        busy,
  output logic        game_end
);

  localparam int unsigned MAX_CG  = (CLR_CYCLES > GAP_CYCLES) ? CLR_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_CG > TRIM_TIMEOUT) ? MAX_CG : TRIM_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_ALL > 1) ? MAX_ALL : 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Each wait loads N-1 so the state is resident for exactly N cycles.
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'((TRIM_TIMEOUT == 0) ? 0 : TRIM_TIMEOUT - 1);
  localparam logic [4:0]       ROUNDS5  = 5'(NUM_ROUNDS);

  state_t      state_q, state_d;
  logic        start_q;
  logic        win_q, win_d;
  logic        start_ok;
  logic [4:0]  rc_inc, ac_inc;
  logic        cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  logic        sub_clr_q, gen_start_q, print_start_q, trim_start_q, busy_q, game_end_q;
  logic [15:0] lv_enable_q;
  logic [4:0]  round_count_q, answer_count_q;
  logic [6:0]  score_q;

  seq_delay_counter #(.W(CNT_W)) u_delay (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .en_i       (1'b1),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    start_ok = start & ~start_q & level_valid & level_ok(level);
    rc_inc   = (round_count_q == ROUNDS5) ? round_count_q : round_count_q + 5'd1;
    ac_inc   = (answer_count_q == ROUNDS5) ? answer_count_q
                                           : answer_count_q + {4'd0, win_q};
    state_d  = state_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_CLEAR;
      S_CLEAR:        if (cnt_zero) state_d = S_GEN;
      S_GEN:          if (gen_done) state_d = S_SHOW;
      S_SHOW:         if (print_done) state_d = S_INPUT;
      S_INPUT: begin
        if (trim_done) begin
          state_d = S_JUDGE;
          win_d   = round_win;
        end else if ((TRIM_TIMEOUT != 0) && cnt_zero) begin
          state_d = S_JUDGE;
          win_d   = 1'b0;
        end
      end
      S_JUDGE: begin
        if (rc_inc == ROUNDS5)    state_d = S_DONE;
        else if (GAP_CYCLES == 0) state_d = S_CLEAR;
        else                      state_d = S_GAP;
      end
      S_GAP:          if (cnt_zero) state_d = S_CLEAR;
      default:        state_d = S_IDLE;
    endcase

    // The counter restarts on every state change; only the entered state's load value matters.
    cnt_load = (state_d != state_q);
    case (state_d)
      S_CLEAR: cnt_val = CLR_LOAD;
      S_GAP:   cnt_val = GAP_LOAD;
      S_INPUT: cnt_val = TO_LOAD;
      default: cnt_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      start_q        <= 1'b0;
      win_q          <= 1'b0;
      sub_clr_q      <= 1'b0;
      gen_start_q    <= 1'b0;
      print_start_q  <= 1'b0;
      trim_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      game_end_q     <= 1'b0;
      lv_enable_q    <= '0;
      round_count_q  <= '0;
      answer_count_q <= '0;
      score_q        <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      win_q         <= win_d;
      sub_clr_q     <= (state_d == S_CLEAR);
      gen_start_q   <= (state_d == S_GEN)   && (state_q != S_GEN);
      print_start_q <= (state_d == S_SHOW)  && (state_q != S_SHOW);
      trim_start_q  <= (state_d == S_INPUT) && (state_q != S_INPUT);
      busy_q        <= (state_d != S_IDLE) && (state_d != S_DONE);
      game_end_q    <= (state_d == S_DONE);

      if (((state_q == S_IDLE) || (state_q == S_DONE)) && start_ok) begin
        lv_enable_q    <= level_mask(level);
        round_count_q  <= '0;
        answer_count_q <= '0;
        score_q        <= '0;
      end else if (state_q == S_DONE) begin
        score_q <= 7'(answer_count_q * POINTS);
      end

      if (state_q == S_JUDGE) begin
        round_count_q  <= rc_inc;
        answer_count_q <= ac_inc;
      end
    end
  end

  assign sub_clr      = sub_clr_q;
  assign gen_start    = gen_start_q;
  assign print_start  = print_start_q;
  assign trim_start   = trim_start_q;
  assign busy         = busy_q;
  assign game_end     = game_end_q;
  assign lv_enable    = lv_enable_q;
  assign round_count  = round_count_q;
  assign answer_count = answer_count_q;
  assign score        = score_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed + randomized bench for game_round_sequencer against a round-level reference model.
module tb_game_round_sequencer;

  localparam int unsigned NR  = 10;
  localparam int unsigned PTS = 10;
  localparam int unsigned CLR = 2;
  localparam int unsigned GAP = 3;
  localparam int unsigned TO  = 20;

  logic        clk = 1'b0;
  logic        rst, start, level_valid, gen_done, print_done, trim_done, round_win;
  logic [2:0]  level;
  logic        sub_clr, gen_start, print_start, trim_start, busy, game_end;
  logic [15:0] lv_enable;
  logic [4:0]  round_count, answer_count;
  logic [6:0]  score;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_rounds, exp_answers;
  logic [15:0] exp_mask;

  game_round_sequencer #(
    .NUM_ROUNDS  (NR),
    .POINTS      (PTS),
    .CLR_CYCLES  (CLR),
    .GAP_CYCLES  (GAP),
    .TRIM_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .level        (level),
    .level_valid  (level_valid),
    .gen_done     (gen_done),
    .print_done   (print_done),
    .trim_done    (trim_done),
    .round_win    (round_win),
    .sub_clr      (sub_clr),
    .gen_start    (gen_start),
    .print_start  (print_start),
    .trim_start   (trim_start),
    .lv_enable    (lv_enable),
    .round_count  (round_count),
    .answer_count (answer_count),
    .score        (score),
    .busy         (busy),
    .game_end     (game_end)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mask_of(input logic [2:0] lv);
    case (lv)
      3'b001:  return 16'h00FF;
      3'b010:  return 16'h0FFF;
      3'b100:  return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {28'd0, sub_clr, gen_start, print_start, trim_start}, 0);
    chk({tag, "_flags"}, {30'd0, busy, game_end}, 0);
    chk({tag, "_lv"}, {16'd0, lv_enable}, 0);
    chk({tag, "_cnt"}, {15'd0, score, answer_count, round_count}, 0);
  endtask

  task automatic start_game(input logic [2:0] lv);
    level = lv; level_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    exp_mask = mask_of(lv); exp_rounds = 0; exp_answers = 0;
    chk("start_sub_clr", {31'd0, sub_clr}, 1);
    chk("start_busy", {30'd0, busy, game_end}, 2);
    chk("start_lv", {16'd0, lv_enable}, {16'd0, exp_mask});
    chk("start_clear", {15'd0, score, answer_count, round_count}, 0);
  endtask

  // Starts in the first CLEAR cycle; k is the INPUT cycle at which trim_done is offered.
  task automatic play_round(input logic win, input int unsigned glat, input int unsigned plat,
                            input int unsigned k, input bit stale, input bit poke);
    int unsigned n;
    logic [4:0] prev;
    logic got;
    n = 0;
    while (sub_clr === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("clr_len", n, CLR);
    chk("gen_after_clr", {30'd0, gen_start, sub_clr}, 2);
    repeat (glat) tick();
    gen_done = 1'b1; print_done = stale;
    tick();
    gen_done = 1'b0; print_done = 1'b0;
    chk("print_start", {30'd0, print_start, gen_start}, 2);
    if (stale) begin
      tick();
      chk("stale_done_ignored", {30'd0, trim_start, print_start}, 0);
    end
    repeat (plat) tick();
    print_done = 1'b1;
    tick();
    print_done = 1'b0;
    chk("trim_start", {30'd0, trim_start, print_start}, 2);

    prev = round_count;
    if (poke) start = 1'b1;
    n = 0;
    for (int unsigned c = 1; c <= 40; c++) begin
      if (c == k && k <= TO) begin
        trim_done = 1'b1; round_win = win;
      end else begin
        trim_done = 1'b0; round_win = (k > TO);
      end
      tick();
      start = 1'b0;
      if (round_count !== prev) begin
        n = c;
        break;
      end
    end
    trim_done = 1'b0; round_win = 1'b0;

    got = (k <= TO) ? win : 1'b0;
    exp_rounds++;
    exp_answers += got;
    chk("judge_latency", n, ((k < TO) ? k : TO) + 1);
    chk("round_count", {27'd0, round_count}, exp_rounds);
    chk("answer_count", {27'd0, answer_count}, exp_answers);

    if (exp_rounds == NR) begin
      chk("done_flags", {30'd0, busy, game_end}, 1);
      tick();
      chk("score", {25'd0, score}, exp_answers * PTS);
      chk("lv_hold", {16'd0, lv_enable}, {16'd0, exp_mask});
    end else begin
      chk("gap_flags", {30'd0, busy, game_end}, 2);
      n = 0;
      while (sub_clr !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("gap_len", n, GAP);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; level = 3'b000; level_valid = 1'b0;
    gen_done = 1'b0; print_done = 1'b0; trim_done = 1'b0; round_win = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Abort mid-SHOW with reset.
    start_game(3'b001);
    repeat (CLR) tick();
    chk("abort_gen", {31'd0, gen_start}, 1);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    chk("abort_show", {31'd0, print_start}, 1);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rst_mid1");
    tick();
    chk_all_zero("rst_mid2");
    rst = 1'b0;
    print_done = 1'b1;
    tick();
    print_done = 1'b0;
    tick();
    chk("post_rst_print", {29'd0, trim_start, busy, sub_clr}, 0);

    // Start with bad level or without level_valid is ignored.
    level = 3'b011; level_valid = 1'b1; start = 1'b1;
    tick(); start = 1'b0; tick();
    chk("bad_level", {30'd0, busy, sub_clr}, 0);
    level = 3'b010; level_valid = 1'b0; start = 1'b1;
    tick(); start = 1'b0; tick();
    chk("no_valid", {30'd0, busy, sub_clr}, 0);

    // Game 1: wins on rounds 1,3,5,7; timeouts on 2 and 4; start poked during round 6.
    start_game(3'b010);
    for (int unsigned r = 1; r <= NR; r++) begin
      play_round((r == 1 || r == 3 || r == 5 || r == 7),
                 $urandom_range(3, 0), $urandom_range(3, 0),
                 (r == 2) ? 25 : (r == 4) ? TO + 1 : $urandom_range(12, 1),
                 (r % 2 == 1), (r == 6));
    end

    // Game 2 from DONE: trim_done coincident with timeout wins, timeout alone loses.
    start_game(3'b100);
    for (int unsigned r = 1; r <= NR; r++) begin
      if (r == 1)      play_round(1'b1, 0, 1, TO, 1'b0, 1'b0);
      else if (r == 2) play_round(1'b1, 1, 0, TO + 1, 1'b0, 1'b0);
      else             play_round(1'($urandom_range(1, 0)), $urandom_range(3, 0),
                                  $urandom_range(3, 0), $urandom_range(TO + 3, 1),
                                  1'($urandom_range(1, 0)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
